// File: rtl/queue_frame_pkg.sv
// Shared definitions for queue_frame_reader.
// Contents:
//   qfr_state_t     - FSM states of the frame reader
//   TRAILER_BYTES   - bytes appended after each payload (len hi, len lo, checksum)
//   MAX_LEN_DEFAULT - default largest element the companion queue can hold
//   LEN_WIDTH       - width of a counter able to hold MAX_LEN_DEFAULT
package queue_frame_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_FETCH  = 3'd1,
        ST_WAIT   = 3'd2,
        ST_SEND   = 3'd3,
        ST_LEN_HI = 3'd4,
        ST_LEN_LO = 3'd5,
        ST_CSUM   = 3'd6
    } qfr_state_t;

    localparam int TRAILER_BYTES   = 3;
    localparam int MAX_LEN_DEFAULT = 2047;
    localparam int LEN_WIDTH       = $clog2(MAX_LEN_DEFAULT + 1);

endpackage

// File: rtl/queue_frame_reader.sv
// queue_frame_reader
// Pops one queued element byte by byte and emits it on a valid/ready byte
// stream, followed by a 3-byte trailer: length high, length low, XOR checksum
// of the payload.
// Ports:
//   i_clk, i_reset_n            - clock, synchronous active-low reset
//   o_read_en                   - pop strobe to the queue
//   i_data, i_has_data          - popped byte and "element still has bytes"
//   i_queue_empty               - queue status, informational only
//   o_tx_data/o_tx_valid/
//   i_tx_ready/o_tx_last        - outgoing byte stream, last marks the checksum
//   o_busy                      - a frame is in progress
//   o_frames_sent               - completed frame counter, wraps at 255
module queue_frame_reader
    import queue_frame_pkg::*;
#(
    parameter int unsigned DATA_WIDTH         = 8,
    parameter logic [10:0] MAX_ELEMENT_LENGTH = 11'd2047
) (
    input  logic                  i_clk,
    input  logic                  i_reset_n,
    output logic                  o_read_en,
    input  logic [DATA_WIDTH-1:0] i_data,
    input  logic                  i_has_data,
    input  logic                  i_queue_empty,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_valid,
    input  logic                  i_tx_ready,
    output logic                  o_tx_last,
    output logic                  o_busy,
    output logic [7:0]            o_frames_sent
);

    localparam int unsigned CntWidth = $clog2(int'(MAX_ELEMENT_LENGTH) + 1);

    qfr_state_t            state_q, state_d;
    logic [CntWidth-1:0]   count_q, count_d;
    logic [DATA_WIDTH-1:0] csum_q, csum_d;
    logic [DATA_WIDTH-1:0] txData_q, txData_d;
    logic [7:0]            framesSent_q, framesSent_d;

    // Length padded to two bytes so the trailer can split it into hi/lo.
    logic [15:0] lenPad;
    assign lenPad = 16'(count_q);

    // Queue emptiness is not needed: starting a frame depends only on
    // i_has_data, so an empty element can never produce a frame.
    logic unusedQueueEmpty;
    assign unusedQueueEmpty = i_queue_empty;

    // State and datapath registers; reset returns to IDLE with valid dropped.
    always_ff @(posedge i_clk) begin
        if (!i_reset_n) begin
            state_q      <= ST_IDLE;
            count_q      <= '0;
            csum_q       <= '0;
            txData_q     <= '0;
            framesSent_q <= '0;
        end else begin
            state_q      <= state_d;
            count_q      <= count_d;
            csum_q       <= csum_d;
            txData_q     <= txData_d;
            framesSent_q <= framesSent_d;
        end
    end

    // Next-state and output decode. The stream outputs are derived from the
    // registered state only, so data/last cannot change while valid waits
    // for ready.
    always_comb begin
        state_d      = state_q;
        count_d      = count_q;
        csum_d       = csum_q;
        txData_d     = txData_q;
        framesSent_d = framesSent_q;
        o_read_en    = 1'b0;
        o_tx_valid   = 1'b0;
        o_tx_last    = 1'b0;
        o_tx_data    = txData_q;

        case (state_q)
            ST_IDLE: begin
                if (i_has_data) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                o_read_en = 1'b1;
                state_d   = ST_WAIT;
            end
            // The queue presents the popped byte one cycle after read_en.
            ST_WAIT: begin
                txData_d = i_data;
                csum_d   = csum_q ^ i_data;
                count_d  = count_q + CntWidth'(1);
                state_d  = ST_SEND;
            end
            // i_has_data already reflects the post-pop state here, so it
            // tells whether more payload follows this byte.
            ST_SEND: begin
                o_tx_valid = 1'b1;
                if (i_tx_ready) begin
                    state_d = i_has_data ? ST_FETCH : ST_LEN_HI;
                end
            end
            ST_LEN_HI: begin
                o_tx_valid = 1'b1;
                o_tx_data  = DATA_WIDTH'(lenPad[15:8]);
                if (i_tx_ready) begin
                    state_d = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                o_tx_valid = 1'b1;
                o_tx_data  = DATA_WIDTH'(lenPad[7:0]);
                if (i_tx_ready) begin
                    state_d = ST_CSUM;
                end
            end
            ST_CSUM: begin
                o_tx_valid = 1'b1;
                o_tx_last  = 1'b1;
                o_tx_data  = csum_q;
                if (i_tx_ready) begin
                    count_d      = '0;
                    csum_d       = '0;
                    framesSent_d = framesSent_q + 8'd1;
                    state_d      = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign o_busy        = (state_q != ST_IDLE);
    assign o_frames_sent = framesSent_q;

endmodule

// File: tb/tb_queue_frame_reader.sv
// Testbench for queue_frame_reader.
// A small behavioural queue (one element current at a time, read latency of
// one cycle) feeds the reader. Expected stream bytes {last, data} are pushed
// into a scoreboard queue when an element is queued and popped/compared as
// the reader hands bytes off.
module tb_queue_frame_reader;

    logic       clk;
    logic       resetN;
    logic       readEn;
    logic [7:0] queueData;
    logic       hasData;
    logic       queueEmpty;
    logic [7:0] txData;
    logic       txValid;
    logic       txReady;
    logic       txLast;
    logic       busy;
    logic [7:0] framesSent;

    queue_frame_reader #(
        .DATA_WIDTH        (8),
        .MAX_ELEMENT_LENGTH(11'd2047)
    ) dut (
        .i_clk        (clk),
        .i_reset_n    (resetN),
        .o_read_en    (readEn),
        .i_data       (queueData),
        .i_has_data   (hasData),
        .i_queue_empty(queueEmpty),
        .o_tx_data    (txData),
        .o_tx_valid   (txValid),
        .i_tx_ready   (txReady),
        .o_tx_last    (txLast),
        .o_busy       (busy),
        .o_frames_sent(framesSent)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural queue storage, filled by the stimulus tasks.
    logic [7:0] memBytes [0:8191];
    int         lenArr   [0:15];
    int         wrPtr  = 0;
    int         elemWr = 0;

    // Queue read side state, owned by the model process below.
    int         rdPtr  = 0;
    int         elemRd = 0;
    int         curRem = 0;
    logic [7:0] qDataReg = 8'h00;

    assign queueData  = qDataReg;
    assign hasData    = (curRem != 0);
    assign queueEmpty = (curRem == 0) && (elemRd == elemWr);

    // Queue model: a pop returns the next byte in the following cycle. The
    // next element becomes current when the reader is idle or as it finishes
    // the checksum of the previous one; the model ignores the reader reset.
    always @(posedge clk) begin
        if (readEn && curRem > 0) begin
            qDataReg <= memBytes[rdPtr];
            rdPtr    <= rdPtr + 1;
            curRem   <= curRem - 1;
        end else if (curRem == 0 && elemRd < elemWr &&
                     ((txValid && txLast && txReady && resetN) || !busy)) begin
            curRem <= lenArr[elemRd];
            elemRd <= elemRd + 1;
        end
    end

    logic [8:0] expQ [$];
    int         errors = 0;
    int         checks = 0;
    int         cycleNo = 0;
    int         popCount = 0;

    logic       obsValid, obsLast, obsRead, obsHas, obsBusy, obsHs;
    logic [7:0] obsData;
    int         obsCycle;

    // Drive ready for one cycle, sample outputs mid-cycle, then advance.
    task automatic tick(input logic rdy);
        txReady = rdy;
        #1;
        obsValid = txValid;
        obsData  = txData;
        obsLast  = txLast;
        obsRead  = readEn;
        obsHas   = hasData;
        obsBusy  = busy;
        obsHs    = txValid && rdy && resetN;
        obsCycle = cycleNo;
        if (readEn && resetN) popCount++;
        @(posedge clk);
        @(negedge clk);
        cycleNo++;
    endtask

    // Queue an element and, optionally, its expected frame.
    task automatic applyStimulus(input logic [7:0] payload [$], input bit pushExp);
        logic [7:0]  sum;
        logic [10:0] len;
        sum = 8'h00;
        len = 11'(payload.size());
        foreach (payload[i]) begin
            memBytes[wrPtr + i] = payload[i];
            sum ^= payload[i];
            if (pushExp) expQ.push_back({1'b0, payload[i]});
        end
        wrPtr += payload.size();
        if (pushExp) begin
            expQ.push_back({1'b0, 5'b00000, len[10:8]});
            expQ.push_back({1'b0, len[7:0]});
            expQ.push_back({1'b1, sum});
        end
        lenArr[elemWr] = payload.size();
        elemWr++;
    endtask

    task automatic test_reset;
        resetN  = 1'b0;
        txReady = 1'b0;
        for (int i = 0; i < 3; i++) tick(1'b0);
        checks++; if (readEn !== 1'b0)     begin errors++; $display("[TB] FAIL reset_read_en: got %b expected 0", readEn); end
        checks++; if (txValid !== 1'b0)    begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", txValid); end
        checks++; if (txLast !== 1'b0)     begin errors++; $display("[TB] FAIL reset_last: got %b expected 0", txLast); end
        checks++; if (txData !== 8'h00)    begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", txData); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (framesSent !== 8'd0) begin errors++; $display("[TB] FAIL reset_frames: got %0d expected 0", framesSent); end
        resetN = 1'b1;
        tick(1'b0);
        checks++; if (busy !== 1'b0) begin errors++; $display("[TB] FAIL idle_after_reset: busy got %b expected 0", busy); end
    endtask

    task automatic test_basic_frame;
        logic [7:0] el [$];
        logic [8:0] exp;
        int hasCycle, firstValid;
        int hsCycles [$];
        el = '{8'hA5, 8'h5A, 8'h01};
        popCount = 0; hasCycle = -1; firstValid = -1;
        applyStimulus(el, 1'b1);
        for (int c = 0; c < 60 && expQ.size() != 0; c++) begin
            tick(1'b1);
            if (obsHas && hasCycle < 0) hasCycle = obsCycle;
            if (obsValid && firstValid < 0) firstValid = obsCycle;
            if (obsHs) begin
                exp = expQ.pop_front();
                hsCycles.push_back(obsCycle);
                checks++;
                if ({obsLast, obsData} !== exp) begin errors++; $display("[TB] FAIL basic_stream: got %h expected %h", {obsLast, obsData}, exp); end
            end
        end
        checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL basic_timeout: %0d bytes outstanding expected 0", expQ.size()); expQ.delete(); end
        checks++; if (firstValid - hasCycle != 3) begin errors++; $display("[TB] FAIL basic_latency: got %0d expected 3", firstValid - hasCycle); end
        checks++;
        if (hsCycles.size() != 6 || hsCycles[1] - hsCycles[0] != 3 || hsCycles[2] - hsCycles[1] != 3 ||
            hsCycles[3] - hsCycles[2] != 1 || hsCycles[4] - hsCycles[3] != 1 || hsCycles[5] - hsCycles[4] != 1) begin
            errors++; $display("[TB] FAIL basic_throughput: got %0d handshakes spanning %0d cycles expected 6 spanning 9",
                               hsCycles.size(), hsCycles.size() > 0 ? hsCycles[hsCycles.size()-1] - hsCycles[0] : 0);
        end
        checks++; if (popCount != 3) begin errors++; $display("[TB] FAIL basic_pops: got %0d expected 3", popCount); end
        checks++; if (framesSent !== 8'd1) begin errors++; $display("[TB] FAIL basic_frames: got %0d expected 1", framesSent); end
    endtask

    task automatic test_backpressure;
        logic [7:0] el [$];
        logic [8:0] exp, prevObs;
        logic rdy;
        bit prevStall;
        el = '{8'h7E};
        popCount = 0; prevStall = 0; prevObs = '0;
        applyStimulus(el, 1'b1);
        for (int c = 0; c < 80 && expQ.size() != 0; c++) begin
            rdy = cycleNo[0];
            tick(rdy);
            if (prevStall) begin
                checks++;
                if (!obsValid || {obsLast, obsData} !== prevObs) begin errors++; $display("[TB] FAIL stall_stable: got v=%b %h expected v=1 %h", obsValid, {obsLast, obsData}, prevObs); end
            end
            prevStall = obsValid && !rdy;
            prevObs   = {obsLast, obsData};
            if (obsHs) begin
                exp = expQ.pop_front();
                checks++;
                if ({obsLast, obsData} !== exp) begin errors++; $display("[TB] FAIL bp_stream: got %h expected %h", {obsLast, obsData}, exp); end
            end
        end
        checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL bp_timeout: %0d bytes outstanding expected 0", expQ.size()); expQ.delete(); end
        for (int i = 0; i < 4; i++) tick(1'b1);
        checks++; if (popCount != 1) begin errors++; $display("[TB] FAIL bp_pops: got %0d expected 1", popCount); end
        checks++; if (framesSent !== 8'd2) begin errors++; $display("[TB] FAIL bp_frames: got %0d expected 2", framesSent); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] el1 [$];
        logic [7:0] el2 [$];
        logic [8:0] exp;
        bit seenLast1, seenValid2;
        int idleTicks;
        el1 = '{8'h11};
        el2 = '{8'h22, 8'h33};
        popCount = 0; seenLast1 = 0; seenValid2 = 0; idleTicks = 0;
        applyStimulus(el1, 1'b1);
        applyStimulus(el2, 1'b1);
        for (int c = 0; c < 80 && expQ.size() != 0; c++) begin
            tick(1'b1);
            if (seenLast1 && !seenValid2) begin
                if (obsValid) seenValid2 = 1;
                else if (!obsBusy) idleTicks++;
            end
            if (obsHs) begin
                exp = expQ.pop_front();
                checks++;
                if ({obsLast, obsData} !== exp) begin errors++; $display("[TB] FAIL b2b_stream: got %h expected %h", {obsLast, obsData}, exp); end
                if (obsLast) seenLast1 = 1;
            end
        end
        checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL b2b_timeout: %0d bytes outstanding expected 0", expQ.size()); expQ.delete(); end
        checks++; if (idleTicks != 1) begin errors++; $display("[TB] FAIL b2b_idle_gap: got %0d expected 1", idleTicks); end
        checks++; if (popCount != 3) begin errors++; $display("[TB] FAIL b2b_pops: got %0d expected 3", popCount); end
        checks++; if (framesSent !== 8'd4) begin errors++; $display("[TB] FAIL b2b_frames: got %0d expected 4", framesSent); end
    endtask

    task automatic test_max_length;
        logic [7:0] el [$];
        logic [8:0] exp;
        int bad;
        for (int i = 0; i < 2047; i++) el.push_back(8'hFF);
        popCount = 0; bad = 0;
        applyStimulus(el, 1'b1);
        for (int c = 0; c < 6400 && expQ.size() != 0; c++) begin
            tick(1'b1);
            if (obsHs) begin
                exp = expQ.pop_front();
                checks++;
                if ({obsLast, obsData} !== exp) begin
                    errors++;
                    if (bad < 8) $display("[TB] FAIL max_stream: got %h expected %h", {obsLast, obsData}, exp);
                    bad++;
                end
            end
        end
        checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL max_timeout: %0d bytes outstanding expected 0", expQ.size()); expQ.delete(); end
        checks++; if (popCount != 2047) begin errors++; $display("[TB] FAIL max_pops: got %0d expected 2047", popCount); end
        checks++; if (framesSent !== 8'd5) begin errors++; $display("[TB] FAIL max_frames: got %0d expected 5", framesSent); end
    endtask

    task automatic test_reset_mid_frame;
        logic [7:0] el [$];
        logic [8:0] exp;
        bit gotFirst, inSend2;
        el = '{8'h01, 8'h02, 8'h03};
        gotFirst = 0; inSend2 = 0;
        applyStimulus(el, 1'b0);
        expQ.push_back(9'h001);
        for (int c = 0; c < 20 && !gotFirst; c++) begin
            tick(1'b1);
            if (obsHs) begin
                gotFirst = 1;
                exp = expQ.pop_front();
                checks++;
                if ({obsLast, obsData} !== exp) begin errors++; $display("[TB] FAIL rst_first_byte: got %h expected %h", {obsLast, obsData}, exp); end
            end
        end
        for (int c = 0; c < 20 && !inSend2; c++) begin
            tick(1'b0);
            if (obsValid) inSend2 = 1;
        end
        checks++; if (!inSend2 || obsData !== 8'h02 || obsLast !== 1'b0) begin errors++; $display("[TB] FAIL rst_second_byte: got v=%b %h expected v=1 002", inSend2, {obsLast, obsData}); end
        resetN = 1'b0;
        tick(1'b1);
        resetN = 1'b1;
        checks++; if (txValid !== 1'b0)    begin errors++; $display("[TB] FAIL rst_valid_drop: got %b expected 0", txValid); end
        checks++; if (busy !== 1'b0)       begin errors++; $display("[TB] FAIL rst_busy: got %b expected 0", busy); end
        checks++; if (framesSent !== 8'd0) begin errors++; $display("[TB] FAIL rst_frames_clear: got %0d expected 0", framesSent); end
        expQ.push_back(9'h003);
        expQ.push_back(9'h000);
        expQ.push_back(9'h001);
        expQ.push_back(9'h103);
        for (int c = 0; c < 60 && expQ.size() != 0; c++) begin
            tick(1'b1);
            if (obsHs) begin
                exp = expQ.pop_front();
                checks++;
                if ({obsLast, obsData} !== exp) begin errors++; $display("[TB] FAIL rst_drain_stream: got %h expected %h", {obsLast, obsData}, exp); end
            end
        end
        checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL rst_timeout: %0d bytes outstanding expected 0", expQ.size()); expQ.delete(); end
        checks++; if (framesSent !== 8'd1) begin errors++; $display("[TB] FAIL rst_frames: got %0d expected 1", framesSent); end
    endtask

    task automatic test_idle_empty;
        bit sawRead, sawValid, sawBusy;
        sawRead = 0; sawValid = 0; sawBusy = 0;
        for (int c = 0; c < 100; c++) begin
            tick(1'b1);
            if (obsRead)  sawRead = 1;
            if (obsValid) sawValid = 1;
            if (obsBusy)  sawBusy = 1;
        end
        checks++; if (sawRead)  begin errors++; $display("[TB] FAIL idle_read_en: got 1 expected 0"); end
        checks++; if (sawValid) begin errors++; $display("[TB] FAIL idle_valid: got 1 expected 0"); end
        checks++; if (sawBusy)  begin errors++; $display("[TB] FAIL idle_busy: got 1 expected 0"); end
    endtask

    initial begin
        resetN  = 1'b0;
        txReady = 1'b0;
        @(negedge clk);
        test_reset;
        test_basic_frame;
        test_backpressure;
        test_back_to_back;
        test_max_length;
        test_reset_mid_frame;
        test_idle_empty;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
